// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester.
// Widths fall back to 32 bits when the platform macros are absent.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_master_pkg;

  localparam int unsigned APB_ADDR_W = `APB_ADDR_WIDTH;
  localparam int unsigned APB_DATA_W = `APB_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // rdata is sized for the widest supported bus
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// Stall watchdog: clear/increment counter that fires on its last
// allowed cycle. TIMEOUT_CYCLES of 0 never fires.
module apb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic fire_o
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    fire_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && ENABLED) begin
      if (cnt_q == LAST) begin
        fire_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one client command at a time through SETUP/ACCESS,
// returning a one-cycle response pulse; stalled slaves are aborted.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
  parameter int unsigned DATA_WIDTH     = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  rsp_t                    rsp_q, rsp_d;
  logic                    rsp_valid_q, rsp_valid_d;

  logic wd_clr;
  logic wd_inc;
  logic wd_fire;

  apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (wd_clr),
    .inc_i  (wd_inc),
    .fire_o (wd_fire)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wd_clr  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // completion takes priority over a watchdog firing this cycle
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_d         = '0;
          if (!pwrite_q) begin
            rsp_d.rdata[DATA_WIDTH-1:0] = prdata;
          end
          rsp_d.slverr  = pslverr;
          state_d       = IDLE;
        end else begin
          wd_inc = 1'b1;
          if (wd_fire) begin
            rsp_valid_d   = 1'b1;
            rsp_d         = '0;
            rsp_d.timeout = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_slverr  = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 4-cycle watchdog.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_addr = 0; cmd_write = 0;
    cmd_wdata = 0; cmd_strb = 0; cmd_prot = 0;
    prdata = 0; pready = 0; pslverr = 0;
    step;
    step;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_pwrite", pwrite, 0);
    rst = 1'b0;
    step;

    // read, zero wait
    cmd(32'h10, 0, 32'hFFFF_FFFF, 4'hF, 3'b000);
    pready = 1; prdata = 32'hDEAD_BEEF;
    step;
    cmd_valid = 0;
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_penable", penable, 0);
    chk("rd_setup_ready", cmd_ready, 0);
    chk("rd_pstrb_zero", pstrb, 0);
    chk("rd_pwrite", pwrite, 0);
    step;
    chk("rd_acc_psel", psel, 1);
    chk("rd_acc_penable", penable, 1);
    chk("rd_acc_paddr", paddr, 32'h10);
    step;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_slverr", rsp_slverr, 0);
    chk("rd_rsp_timeout", rsp_timeout, 0);
    chk("rd_rsp_psel", psel, 0);
    chk("rd_rsp_ready", cmd_ready, 1);
    prdata = 32'h1111_2222;
    step;
    chk("rd_pulse_end", rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // write, 3 wait states; pready on the 4th ACCESS also beats the watchdog
    pready = 0;
    cmd(32'h24, 1, 32'h1234_5678, 4'b0011, 3'b010);
    step;
    cmd_valid = 0;
    chk("wr_setup_psel", psel, 1);
    for (int i = 0; i < 4; i++) begin
      step;
      chk("wr_acc_penable", penable, 1);
      chk("wr_acc_paddr", paddr, 32'h24);
      chk("wr_acc_pwdata", pwdata, 32'h1234_5678);
      chk("wr_acc_pstrb", pstrb, 4'b0011);
      chk("wr_acc_pprot", pprot, 3'b010);
      chk("wr_acc_pwrite", pwrite, 1);
      chk("wr_acc_no_rsp", rsp_valid, 0);
      pready = (i == 3);
    end
    step;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    chk("wr_rsp_psel", psel, 0);

    // pslverr and prdata while pready=0 are ignored
    pready = 0; pslverr = 1; prdata = 32'hBAD0_0BAD;
    cmd(32'h40, 0, 0, 4'hF, 0);
    step;
    cmd_valid = 0;
    step;
    chk("ign_acc1", penable, 1);
    pready = 1; pslverr = 0; prdata = 32'h600D_0001;
    step;
    chk("ign_rsp_valid", rsp_valid, 1);
    chk("ign_rsp_slverr", rsp_slverr, 0);
    chk("ign_rsp_rdata", rsp_rdata, 32'h600D_0001);

    // slave error at pready
    pslverr = 1; prdata = 32'h0000_00E5;
    cmd(32'h44, 0, 0, 0, 0);
    step;
    cmd_valid = 0;
    step;
    step;
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_slverr", rsp_slverr, 1);
    chk("err_rsp_rdata", rsp_rdata, 32'h0000_00E5);
    pslverr = 0;

    // watchdog: pready stuck low for 4 ACCESS cycles
    pready = 0; pslverr = 1; prdata = 32'hFEED_FACE;
    cmd(32'h50, 0, 0, 0, 3'b001);
    step;
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("to_acc_psel", psel, 1);
      chk("to_acc_penable", penable, 1);
      chk("to_acc_no_rsp", rsp_valid, 0);
    end
    step;
    chk("to_psel", psel, 0);
    chk("to_penable", penable, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_slverr", rsp_slverr, 0);
    chk("to_rsp_rdata", rsp_rdata, 0);
    pslverr = 0;
    step;
    chk("to_pulse_end", rsp_valid, 0);
    chk("to_hold", rsp_timeout, 1);

    // back-to-back with cmd_valid held high
    pready = 1;
    for (int k = 0; k < 3; k++) begin
      cmd(32'h100 + 32'(4 * k), 0, 0, 0, 0);
      prdata = 32'hA000_0000 + 32'(k);
      step;
      chk("b2b_setup_psel", psel, 1);
      chk("b2b_setup_penable", penable, 0);
      chk("b2b_setup_ready", cmd_ready, 0);
      chk("b2b_setup_paddr", paddr, 32'h100 + 32'(4 * k));
      step;
      chk("b2b_acc_ready", cmd_ready, 0);
      chk("b2b_acc_penable", penable, 1);
      step;
      chk("b2b_rsp_valid", rsp_valid, 1);
      chk("b2b_rsp_rdata", rsp_rdata, 32'hA000_0000 + 32'(k));
      chk("b2b_rsp_ready", cmd_ready, 1);
    end
    cmd_valid = 0;
    step;
    chk("b2b_idle_psel", psel, 0);

    // asynchronous reset in the middle of a stalled ACCESS
    pready = 0;
    cmd(32'h200, 1, 32'hCAFE_F00D, 4'hF, 0);
    step;
    cmd_valid = 0;
    step;
    step;
    chk("mr_pre_penable", penable, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_psel_drop", psel, 0);
    chk("mr_penable_drop", penable, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_paddr_clr", paddr, 0);
    step;
    chk("mr_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    step;
    chk("mr_after_no_rsp", rsp_valid, 0);
    chk("mr_after_ready", cmd_ready, 1);
    pready = 1; prdata = 32'h0BAD_F00D;
    cmd(32'h30, 0, 0, 0, 0);
    step;
    cmd_valid = 0;
    chk("mr_next_psel", psel, 1);
    step;
    step;
    chk("mr_next_rsp", rsp_valid, 1);
    chk("mr_next_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk("mr_next_timeout", rsp_timeout, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the bus side consumed by our APB slave blocks.
- Accepts one command at a time from a local client over a valid/ready handshake and runs the APB SETUP→ACCESS sequence.
- Waits for PREADY, then returns read data and error status as a one-cycle response pulse.
- Includes a watchdog that aborts ACCESS phases stalled by an unresponsive slave.

Parameters:
- ADDR_WIDTH, default `APB_ADDR_WIDTH (32): width of the address bus.
- DATA_WIDTH, default `APB_DATA_WIDTH (32): width of the data bus; must be a multiple of 8.
- TIMEOUT_CYCLES, default 16: maximum ACCESS cycles without PREADY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  client command present.
- cmd_ready  out  1  master can accept a command.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborts.
- rsp_slverr  out  1  slave signalled PSLVERR.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; forced to 0 on reads.
- pprot  out  3  APB protection.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Bus registers (paddr, pwdata, pstrb, pprot, pwrite) = 0.
  - Watchdog counter = 0.
- All outputs are registered. cmd_ready is a decode of state (1 only in IDLE).
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid&&cmd_ready: latch addr/write/wdata/strb/prot into the p* registers and go to SETUP.
  - Latch pstrb=0 when cmd_write=0.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, cmd_ready=0.
  - Next state is always ACCESS; counter cleared.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite, pwdata, pstrb, pprot held stable.
  - pready sampled each cycle.
  - pready=1: next cycle psel=0, penable=0, rsp_valid=1 for one cycle.
    - rsp_rdata = prdata if read, else 0.
    - rsp_slverr = pslverr; rsp_timeout=0.
    - Go to IDLE.
  - pready=0: counter increments.
  - Watchdog: TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1 with pready=0.
    - Next cycle psel=0, penable=0, rsp_valid=1, rsp_timeout=1, rsp_slverr=0, rsp_rdata=0.
    - Go to IDLE.
  - pready=1 in the same cycle the watchdog would fire: normal completion wins; no timeout.
- Timing:
  - Minimum transfer: accept edge → SETUP → ACCESS(pready=1) → rsp_valid in IDLE.
  - Back-to-back commands are spaced 3 cycles apart (command accepted in IDLE during the response cycle).
- Response: rsp_valid has no backpressure; the client must take it. rsp_* hold their values until the next response; only rsp_valid pulses.
- Boundaries:
  - cmd_valid outside IDLE is ignored (not accepted).
  - prdata/pslverr are ignored when pready=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it does not wrap because the abort fires first.
- Reset mid-transfer drops psel/penable asynchronously; no response is generated for the aborted command.

Decomposition:
- Package apb_master_pkg:
  - state enum {IDLE, SETUP, ACCESS} (2 bits).
  - localparams for default widths derived from definition.sv macros.
  - response struct {rdata, slverr, timeout}.
- Sub-module apb_watchdog: clear/enable/fire counter, reused later by the slave-side bridge.
- FSM and bus registers stay in apb_master.

Test Plan:
- Read, zero wait: cmd addr=0x10, write=0; slave pready=1 in first ACCESS with prdata=0xDEADBEEF → psel high 2 cycles, penable 1 cycle; rsp_valid with rsp_rdata=0xDEADBEEF, slverr=0, timeout=0.
- Write, 3 waits: addr=0x24, wdata=0x12345678, strb=4'b0011, prot=3'b010; pready after 3 low cycles → paddr/pwdata/pstrb/pprot stable for 4 ACCESS cycles; rsp_rdata=0.
- Slave error: read with pslverr=1 at pready → rsp_slverr=1. pslverr=1 while pready=0 → ignored.
- Timeout: TIMEOUT_CYCLES=4, pready stuck 0 → 4 ACCESS cycles, then psel=0, rsp_timeout=1. Repeat with pready rising on the 4th cycle → normal completion, timeout=0.
- Back-to-back: cmd_valid held high with 3 commands → accepted 3 cycles apart; cmd_ready=0 in SETUP/ACCESS; responses in order.
- Reset during ACCESS: assert rst mid-wait → psel/penable drop immediately, no rsp_valid; after release cmd_ready=1 and the next command completes normally.
